open_list_pop: RTL and testbench

- Reader/extractor side of the A* open list; the existing sort block writes entries into a shared RAM in ascending f-cost order, with entry 0 holding the minimum.
- On request, this block takes entry 0, returns it to the search controller and compacts the list by shifting entries 1..N-1 down one slot.
- It then signals sort to decrement its count.
- Sits between the open-list RAM/sort block and the A* control FSM.

---
 rtl/open_list_pop.sv | 145 ++++++++++++++
 tb/tb_open_list_pop.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/open_list_pop.sv
// Pops the minimum entry (slot 0) from the sorted A* open list and compacts the RAM.
// Define POP_CLEAR_TAIL_EN to overwrite the vacated tail slot with an all-ones sentinel.
module open_list_pop #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int NW    = 8,
   parameter int FW    = 10
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Pop_Req,
   input  logic [AW:0]        List_Count,
   output logic               Pop_Ack,
   output logic               Pop_Empty,
   output logic [NW-1:0]      Pop_Node,
   output logic [FW-1:0]      Pop_Cost,
   output logic               Busy,
   output logic               Dec_Count,
   output logic [AW-1:0]      Mem_Addr,
   input  logic [FW+NW-1:0]   Mem_Rd_Data,
   output logic               Mem_Wr_En,
   output logic [FW+NW-1:0]   Mem_Wr_Data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_HEAD,
      S_CAPTURE,
      S_SHIFT_RD,
      S_SHIFT_WR,
      S_CLEAR,
      S_DONE
   } state_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

`ifdef POP_CLEAR_TAIL_EN
   localparam state_t LAST_S = S_CLEAR;
`else
   localparam state_t LAST_S = S_DONE;
`endif

   state_t          state_q, state_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [AW:0]     idx_q, idx_d;
   logic            empty_q, empty_d;
   logic [NW-1:0]   node_q, node_d;
   logic [FW-1:0]   cost_q, cost_d;
   logic [AW:0]     req_cnt;

   assign req_cnt = (List_Count > DEPTH_C) ? DEPTH_C : List_Count;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         empty_q <= 1'b0;
         node_q  <= '0;
         cost_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         empty_q <= empty_d;
         node_q  <= node_d;
         cost_q  <= cost_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      empty_d = empty_q;
      node_d  = node_q;
      cost_d  = cost_q;
      unique case (state_q)
         S_IDLE: begin
            if (Pop_Req) begin
               cnt_d = req_cnt;
               if (req_cnt == '0) begin
                  empty_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  empty_d = 1'b0;
                  state_d = S_RD_HEAD;
               end
            end
         end
         S_RD_HEAD: state_d = S_CAPTURE;
         S_CAPTURE: begin
            {cost_d, node_d} = Mem_Rd_Data;
            idx_d = (AW+1)'(1);
            state_d = (cnt_q == (AW+1)'(1)) ? LAST_S : S_SHIFT_RD;
         end
         S_SHIFT_RD: state_d = S_SHIFT_WR;
         S_SHIFT_WR: begin
            idx_d = idx_q + (AW+1)'(1);
            // Stop once the last occupied slot has moved down.
            state_d = (idx_q + (AW+1)'(1) == cnt_q) ? LAST_S : S_SHIFT_RD;
         end
`ifdef POP_CLEAR_TAIL_EN
         S_CLEAR: state_d = S_DONE;
`endif
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      Mem_Addr    = '0;
      Mem_Wr_En   = 1'b0;
      Mem_Wr_Data = '0;
      Pop_Ack     = 1'b0;
      Pop_Empty   = 1'b0;
      Dec_Count   = 1'b0;
      Busy        = (state_q != S_IDLE);
      unique case (state_q)
         S_SHIFT_RD: Mem_Addr = idx_q[AW-1:0];
         S_SHIFT_WR: begin
            Mem_Addr    = idx_q[AW-1:0] - AW'(1);
            Mem_Wr_En   = 1'b1;
            Mem_Wr_Data = Mem_Rd_Data;
         end
`ifdef POP_CLEAR_TAIL_EN
         S_CLEAR: begin
            Mem_Addr    = cnt_q[AW-1:0] - AW'(1);
            Mem_Wr_En   = 1'b1;
            Mem_Wr_Data = '1;
         end
`endif
         S_DONE: begin
            Pop_Ack   = 1'b1;
            Pop_Empty = empty_q;
            Dec_Count = !empty_q;
         end
         default: ;
      endcase
   end

   assign Pop_Node = node_q;
   assign Pop_Cost = cost_q;

endmodule

// File: tb/tb_open_list_pop.sv
// Directed bench for open_list_pop with a behavioural synchronous-read RAM.
// Expected latencies grow by one when POP_CLEAR_TAIL_EN is defined.
module tb_open_list_pop;

   localparam int AW = 6;
   localparam int NW = 8;
   localparam int FW = 10;
`ifdef POP_CLEAR_TAIL_EN
   localparam int XL = 1;
`else
   localparam int XL = 0;
`endif
   localparam logic [17:0] ONES = '1;

   logic              Clk = 1'b0;
   logic              Reset = 1'b0;
   logic              Pop_Req = 1'b0;
   logic [AW:0]       List_Count = '0;
   logic              Pop_Ack, Pop_Empty, Busy, Dec_Count, Mem_Wr_En;
   logic [NW-1:0]     Pop_Node;
   logic [FW-1:0]     Pop_Cost;
   logic [AW-1:0]     Mem_Addr;
   logic [FW+NW-1:0]  Mem_Rd_Data = '0;
   logic [FW+NW-1:0]  Mem_Wr_Data;

   logic [17:0] ram [64];
   int wr_cnt = 0;
   int errors = 0;
   int checks = 0;

   open_list_pop dut (
      .Clk(Clk), .Reset(Reset), .Pop_Req(Pop_Req), .List_Count(List_Count),
      .Pop_Ack(Pop_Ack), .Pop_Empty(Pop_Empty), .Pop_Node(Pop_Node),
      .Pop_Cost(Pop_Cost), .Busy(Busy), .Dec_Count(Dec_Count),
      .Mem_Addr(Mem_Addr), .Mem_Rd_Data(Mem_Rd_Data),
      .Mem_Wr_En(Mem_Wr_En), .Mem_Wr_Data(Mem_Wr_Data)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      Mem_Rd_Data <= ram[Mem_Addr];
      if (Mem_Wr_En) begin
         ram[Mem_Addr] = Mem_Wr_Data;
         wr_cnt++;
      end
   end

   function automatic logic [17:0] ent(input int c, input int n);
      return {10'(c), 8'(n)};
   endfunction

   task automatic run_pop(input logic [AW:0] cnt, output int lat,
                          output logic emp, output logic dec);
      @(negedge Clk);
      List_Count = cnt;
      Pop_Req = 1'b1;
      wr_cnt = 0;
      @(posedge Clk);
      #1 Pop_Req = 1'b0;
      lat = 1;
      while (!Pop_Ack && lat < 400) begin
         @(posedge Clk);
         #1;
         lat++;
      end
      emp = Pop_Empty;
      dec = Dec_Count;
      @(negedge Clk);
   endtask

   task automatic test_reset();
      checks++;
      if ({Pop_Ack, Pop_Empty, Busy, Dec_Count, Mem_Wr_En} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctl: got %b want 00000",
                  {Pop_Ack, Pop_Empty, Busy, Dec_Count, Mem_Wr_En});
      end
      checks++;
      if ({Pop_Node, Pop_Cost, Mem_Addr, Mem_Wr_Data} !== '0) begin
         errors++;
         $display("FAIL reset_data: got node %h cost %h addr %h wd %h want 0",
                  Pop_Node, Pop_Cost, Mem_Addr, Mem_Wr_Data);
      end
      @(negedge Clk);
      Reset = 1'b1;
      ram[0] = ent(5, 8'h11);
      ram[1] = ent(9, 8'h22);
      ram[2] = ent(12, 8'h33);
      ram[3] = ent(20, 8'h44);
      @(negedge Clk);
      List_Count = 7'd4;
      Pop_Req = 1'b1;
      repeat (3) @(posedge Clk);
      #1 Pop_Req = 1'b0;
      checks++;
      if (Busy !== 1'b1 || Pop_Node !== 8'h11) begin
         errors++;
         $display("FAIL reset_midrun_pre: got busy %b node %h want 1 11",
                  Busy, Pop_Node);
      end
      Reset = 1'b0;
      #1;
      checks++;
      if ({Busy, Pop_Ack, Mem_Wr_En, Mem_Addr, Pop_Node, Pop_Cost} !== '0) begin
         errors++;
         $display("FAIL reset_midrun: got busy %b ack %b we %b addr %h node %h cost %h want 0",
                  Busy, Pop_Ack, Mem_Wr_En, Mem_Addr, Pop_Node, Pop_Cost);
      end
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      checks++;
      if (Busy !== 1'b0 || Pop_Ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got busy %b ack %b want 0 0", Busy, Pop_Ack);
      end
   endtask

   task automatic test_single();
      int lat;
      logic emp, dec;
      ram[0] = ent(7, 8'h05);
      ram[1] = ent(30, 8'h66);
      run_pop(7'd1, lat, emp, dec);
      checks++;
      if (lat !== 3 + XL) begin
         errors++;
         $display("FAIL single_lat: got %0d want %0d", lat, 3 + XL);
      end
      checks++;
      if (Pop_Cost !== 10'd7 || Pop_Node !== 8'h05) begin
         errors++;
         $display("FAIL single_data: got %0d/%h want 7/05", Pop_Cost, Pop_Node);
      end
      checks++;
      if (emp !== 1'b0 || dec !== 1'b1) begin
         errors++;
         $display("FAIL single_flags: got emp %b dec %b want 0 1", emp, dec);
      end
      checks++;
      if (wr_cnt !== XL) begin
         errors++;
         $display("FAIL single_writes: got %0d want %0d", wr_cnt, XL);
      end
      checks++;
      if (ram[0] !== ((XL == 1) ? ONES : ent(7, 8'h05))) begin
         errors++;
         $display("FAIL single_ram0: got %h", ram[0]);
      end
   endtask

   task automatic test_empty();
      int lat;
      logic emp, dec;
      run_pop(7'd0, lat, emp, dec);
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL empty_lat: got %0d want 1", lat);
      end
      checks++;
      if (emp !== 1'b1 || dec !== 1'b0) begin
         errors++;
         $display("FAIL empty_flags: got emp %b dec %b want 1 0", emp, dec);
      end
      checks++;
      if (wr_cnt !== 0) begin
         errors++;
         $display("FAIL empty_writes: got %0d want 0", wr_cnt);
      end
      checks++;
      if (Pop_Cost !== 10'd7 || Pop_Node !== 8'h05) begin
         errors++;
         $display("FAIL empty_hold: got %0d/%h want 7/05", Pop_Cost, Pop_Node);
      end
   endtask

   task automatic test_pop4();
      int lat;
      logic emp, dec;
      ram[0] = ent(5, 8'h11);
      ram[1] = ent(9, 8'h22);
      ram[2] = ent(12, 8'h33);
      ram[3] = ent(20, 8'h44);
      ram[4] = ent(99, 8'h55);
      run_pop(7'd4, lat, emp, dec);
      checks++;
      if (lat !== 9 + XL) begin
         errors++;
         $display("FAIL pop4_lat: got %0d want %0d", lat, 9 + XL);
      end
      checks++;
      if (Pop_Cost !== 10'd5 || Pop_Node !== 8'h11) begin
         errors++;
         $display("FAIL pop4_data: got %0d/%h want 5/11", Pop_Cost, Pop_Node);
      end
      checks++;
      if (emp !== 1'b0 || dec !== 1'b1) begin
         errors++;
         $display("FAIL pop4_flags: got emp %b dec %b want 0 1", emp, dec);
      end
      checks++;
      if (wr_cnt !== 3 + XL) begin
         errors++;
         $display("FAIL pop4_writes: got %0d want %0d", wr_cnt, 3 + XL);
      end
      checks++;
      if (ram[0] !== ent(9, 8'h22) || ram[1] !== ent(12, 8'h33) ||
          ram[2] !== ent(20, 8'h44)) begin
         errors++;
         $display("FAIL pop4_ram: got %h %h %h want %h %h %h", ram[0], ram[1],
                  ram[2], ent(9, 8'h22), ent(12, 8'h33), ent(20, 8'h44));
      end
      checks++;
      if (ram[3] !== ((XL == 1) ? ONES : ent(20, 8'h44)) ||
          ram[4] !== ent(99, 8'h55)) begin
         errors++;
         $display("FAIL pop4_tail: got %h %h", ram[3], ram[4]);
      end
   endtask

   task automatic test_back_to_back();
      int acks = 0;
      int idle = 0;
      int cyc = 0;
      logic [FW-1:0] c1 = '0;
      logic [FW-1:0] c2 = '0;
      ram[0] = ent(3, 8'h01);
      ram[1] = ent(6, 8'h02);
      ram[2] = ent(8, 8'h03);
      @(negedge Clk);
      List_Count = 7'd3;
      Pop_Req = 1'b1;
      while (acks < 2 && cyc < 100) begin
         @(posedge Clk);
         #1;
         cyc++;
         if (acks == 1 && !Busy) idle++;
         if (Pop_Ack) begin
            acks++;
            if (acks == 1) begin
               c1 = Pop_Cost;
               if (Dec_Count) List_Count = List_Count - 7'd1;
            end else begin
               c2 = Pop_Cost;
               Pop_Req = 1'b0;
            end
         end
      end
      Pop_Req = 1'b0;
      repeat (6) begin
         @(posedge Clk);
         #1;
         if (Pop_Ack) acks++;
      end
      checks++;
      if (acks !== 2) begin
         errors++;
         $display("FAIL b2b_acks: got %0d want 2", acks);
      end
      checks++;
      if (c1 !== 10'd3 || c2 !== 10'd6) begin
         errors++;
         $display("FAIL b2b_costs: got %0d,%0d want 3,6", c1, c2);
      end
      checks++;
      if (idle !== 1) begin
         errors++;
         $display("FAIL b2b_idle: got %0d want 1", idle);
      end
   endtask

   task automatic test_ignore();
      int lat = 0;
      int acks = 0;
      ram[0] = ent(2, 8'h0A);
      ram[1] = ent(4, 8'h0B);
      ram[2] = ent(6, 8'h0C);
      ram[3] = ent(40, 8'h0D);
      ram[4] = ent(41, 8'h0E);
      ram[5] = ent(42, 8'h0F);
      @(negedge Clk);
      List_Count = 7'd3;
      Pop_Req = 1'b1;
      wr_cnt = 0;
      @(posedge Clk);
      #1 Pop_Req = 1'b0;
      for (int k = 1; k < 30; k++) begin
         if (k == 3) List_Count = 7'd6;
         if (k >= 2 && k <= 5) Pop_Req = k[0];
         if (k == 6) Pop_Req = 1'b0;
         if (Pop_Ack) begin
            acks++;
            if (lat == 0) lat = k;
         end
         @(posedge Clk);
         #1;
      end
      List_Count = 7'd0;
      checks++;
      if (acks !== 1 || lat !== 7 + XL) begin
         errors++;
         $display("FAIL ignore_ack: got %0d acks lat %0d want 1 lat %0d",
                  acks, lat, 7 + XL);
      end
      checks++;
      if (wr_cnt !== 2 + XL) begin
         errors++;
         $display("FAIL ignore_writes: got %0d want %0d", wr_cnt, 2 + XL);
      end
      checks++;
      if (ram[0] !== ent(4, 8'h0B) || ram[1] !== ent(6, 8'h0C) ||
          ram[3] !== ent(40, 8'h0D)) begin
         errors++;
         $display("FAIL ignore_ram: got %h %h %h", ram[0], ram[1], ram[3]);
      end
   endtask

   task automatic test_clamp();
      int lat;
      logic emp, dec;
      for (int i = 0; i < 64; i++) ram[i] = ent(2 * i + 1, i);
      run_pop(7'd100, lat, emp, dec);
      checks++;
      if (lat !== 129 + XL) begin
         errors++;
         $display("FAIL clamp_lat: got %0d want %0d", lat, 129 + XL);
      end
      checks++;
      if (wr_cnt !== 63 + XL || Pop_Cost !== 10'd1 || Pop_Node !== 8'h00) begin
         errors++;
         $display("FAIL clamp_pop: got writes %0d cost %0d node %h want %0d 1 00",
                  wr_cnt, Pop_Cost, Pop_Node, 63 + XL);
      end
      checks++;
      if (ram[0] !== ent(3, 1) || ram[62] !== ent(127, 63) ||
          ram[63] !== ((XL == 1) ? ONES : ent(127, 63))) begin
         errors++;
         $display("FAIL clamp_ram: got %h %h %h", ram[0], ram[62], ram[63]);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = '0;
      #2;
      test_reset();
      test_single();
      test_empty();
      test_pop4();
      test_back_to_back();
      test_ignore();
      test_clamp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
